// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: parameter limits and Gray/binary helpers.
package fifo_pkg;

    localparam int unsigned MIN_ADDR_WIDTH  = 2;
    localparam int unsigned MAX_ADDR_WIDTH  = 8;
    localparam int unsigned MIN_SYNC_STAGES = 2;
    localparam int unsigned MAX_SYNC_STAGES = 4;

    // Widest pointer any FIFO instance can carry (address bits plus wrap bit).
    localparam int unsigned PTR_MAX_W = MAX_ADDR_WIDTH + 1;

    typedef logic [PTR_MAX_W-1:0] ptr_max_t;

    // Binary to reflected Gray code.
    function automatic ptr_max_t bin2gray(input ptr_max_t bin);
        return bin ^ (bin >> 1);
    endfunction

    // Reflected Gray code to binary (prefix XOR from the MSB down).
    function automatic ptr_max_t gray2bin(input ptr_max_t gray);
        ptr_max_t bin;
        bin[PTR_MAX_W-1] = gray[PTR_MAX_W-1];
        for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/gray2bin.sv
// Pure combinational Gray-to-binary converter; shared by both FIFO pointer sides.
module gray2bin
    import fifo_pkg::*;
#(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] gray_i,
    output logic [W-1:0] bin_o
);

    // Each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        bin_o[W-1] = gray_i[W-1];
        for (int i = W - 2; i >= 0; i--) begin
            bin_o[i] = bin_o[i+1] ^ gray_i[i];
        end
    end

endmodule

// File: rtl/wptr_full_level.sv
// Write-side pointer and flag controller for the async FIFO. Synchronises the read Gray
// pointer into the write domain, advances binary/Gray write pointers, and produces
// registered full, almost_full, fill level and a sticky overflow flag.
module wptr_full_level
    import fifo_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 3,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned AFULL_THRESH = 6
) (
    input  logic                  wclk,
    input  logic                  rst_n,
    input  logic                  winc,
    input  logic [ADDR_WIDTH:0]   rptr,
    input  logic                  ovf_clr,
    output logic                  wen,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [ADDR_WIDTH:0]   wptr,
    output logic                  full,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   wlevel,
    output logic                  overflow
);

    localparam int unsigned AW = ADDR_WIDTH;
    localparam logic [AW:0] AfullThresh = (AW + 1)'(AFULL_THRESH);

    // Elaboration-time parameter legality.
    if (ADDR_WIDTH < MIN_ADDR_WIDTH || ADDR_WIDTH > MAX_ADDR_WIDTH) begin : gen_bad_addr_width
        $error("wptr_full_level: ADDR_WIDTH out of range");
    end
    if (SYNC_STAGES < MIN_SYNC_STAGES || SYNC_STAGES > MAX_SYNC_STAGES) begin : gen_bad_sync
        $error("wptr_full_level: SYNC_STAGES out of range");
    end
    if (AFULL_THRESH < 1 || AFULL_THRESH > (1 << ADDR_WIDTH)) begin : gen_bad_afull
        $error("wptr_full_level: AFULL_THRESH out of range");
    end

    logic [SYNC_STAGES-1:0][AW:0] sync_q;
    logic [AW:0] rq;
    logic [AW:0] rbin;

    logic [AW:0] wbin_q, wbin_d;
    logic [AW:0] wgray_q, wgray_d;
    logic [AW:0] level_q, level_d;
    logic        full_q, full_d;
    logic        afull_q, afull_d;
    logic        ovf_q, ovf_d;

    // Read-pointer synchroniser: plain flop chain, no logic between stages.
    for (genvar i = 0; i < int'(SYNC_STAGES); i++) begin : gen_sync
        if (i == 0) begin : gen_first
            // First stage samples the asynchronous read pointer.
            always_ff @(posedge wclk) begin
                if (!rst_n) begin
                    sync_q[i] <= '0;
                end else begin
                    sync_q[i] <= rptr;
                end
            end
        end else begin : gen_rest
            // Later stages only resolve metastability.
            always_ff @(posedge wclk) begin
                if (!rst_n) begin
                    sync_q[i] <= '0;
                end else begin
                    sync_q[i] <= sync_q[i-1];
                end
            end
        end
    end

    assign rq = sync_q[SYNC_STAGES-1];

    gray2bin #(
        .W(AW + 1)
    ) u_rq_gray2bin (
        .gray_i(rq),
        .bin_o (rbin)
    );

    // Next-state pointers and flags; every flag sees the post-write pointer.
    always_comb begin
        wen     = rst_n & winc & ~full_q;
        wbin_d  = wbin_q + {{AW{1'b0}}, wen};
        wgray_d = wbin_d ^ (wbin_d >> 1);
        level_d = wbin_d - rbin;
        // Full when write Gray equals read Gray with the top two bits inverted.
        full_d  = (wgray_d == {~rq[AW:AW-1], rq[AW-2:0]});
        afull_d = (level_d >= AfullThresh);
        // A fresh overflow event outranks a same-cycle clear.
        ovf_d   = ovf_q;
        if (winc && full_q) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    // Pointer and flag registers with synchronous reset.
    always_ff @(posedge wclk) begin
        if (!rst_n) begin
            wbin_q  <= '0;
            wgray_q <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            afull_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            wbin_q  <= wbin_d;
            wgray_q <= wgray_d;
            level_q <= level_d;
            full_q  <= full_d;
            afull_q <= afull_d;
            ovf_q   <= ovf_d;
        end
    end

    assign waddr       = wbin_q[AW-1:0];
    assign wptr        = wgray_q;
    assign full        = full_q;
    assign almost_full = afull_q;
    assign wlevel      = level_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_wptr_full_level.sv
// Self-checking bench for wptr_full_level (ADDR_WIDTH=3, SYNC_STAGES=2, AFULL_THRESH=6).
module tb_wptr_full_level;

    logic       wclk = 1'b0;
    logic       rst_n = 1'b0;
    logic       winc = 1'b0;
    logic [3:0] rptr = '0;
    logic       ovf_clr = 1'b0;
    logic       wen;
    logic [2:0] waddr;
    logic [3:0] wptr;
    logic       full;
    logic       almost_full;
    logic [3:0] wlevel;
    logic       overflow;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic       rst_n;
        logic       winc;
        logic [3:0] rptr;
        logic       clr;
        logic       wen;
        logic [2:0] waddr;
        logic [3:0] wptr;
        logic       full;
        logic       afull;
        logic [3:0] lvl;
        logic       ovf;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];

    wptr_full_level #(
        .ADDR_WIDTH  (3),
        .SYNC_STAGES (2),
        .AFULL_THRESH(6)
    ) dut (
        .wclk       (wclk),
        .rst_n      (rst_n),
        .winc       (winc),
        .rptr       (rptr),
        .ovf_clr    (ovf_clr),
        .wen        (wen),
        .waddr      (waddr),
        .wptr       (wptr),
        .full       (full),
        .almost_full(almost_full),
        .wlevel     (wlevel),
        .overflow   (overflow)
    );

    always #5 wclk = ~wclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [3:0] g(input int b);
        logic [3:0] x;
        x = b[3:0];
        return x ^ (x >> 1);
    endfunction

    function automatic vec_t mk(input logic r, input logic wi, input logic [3:0] rp,
                                input logic c, input logic we, input logic [2:0] wa,
                                input logic [3:0] wp, input logic f, input logic af,
                                input logic [3:0] l, input logic o);
        vec_t v;
        v.rst_n = r; v.winc = wi; v.rptr = rp; v.clr = c;
        v.wen = we; v.waddr = wa; v.wptr = wp; v.full = f; v.afull = af; v.lvl = l; v.ovf = o;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    // Drive one cycle; wen/waddr are checked before the edge, registered outputs after.
    task automatic apply(input vec_t v, input int idx);
        vec_t e;
        @(negedge wclk);
        rst_n   = v.rst_n;
        winc    = v.winc;
        rptr    = v.rptr;
        ovf_clr = v.clr;
        exp_q.push_back(v);
        #1;
        chk("wen", idx, 32'(wen), 32'(v.wen));
        chk("waddr", idx, 32'(waddr), 32'(v.waddr));
        @(posedge wclk);
        #1;
        e = exp_q.pop_front();
        chk("wptr", idx, 32'(wptr), 32'(e.wptr));
        chk("full", idx, 32'(full), 32'(e.full));
        chk("almost_full", idx, 32'(almost_full), 32'(e.afull));
        chk("wlevel", idx, 32'(wlevel), 32'(e.lvl));
        chk("overflow", idx, 32'(overflow), 32'(e.ovf));
    endtask

    task automatic hard_reset();
        @(negedge wclk);
        rst_n = 1'b0; winc = 1'b0; rptr = '0; ovf_clr = 1'b0;
        @(negedge wclk);
    endtask

    initial begin
        //               rst win rptr clr | wen waddr wptr full af lvl ovf
        // Reset with winc high: no write, all zero.
        vecs.push_back(mk(0, 1, 4'd0, 0,   0, 3'd0, 4'd0,  0, 0, 4'd0, 0));
        // Eight writes, rptr held 0.
        vecs.push_back(mk(1, 1, 4'd0, 0,   1, 3'd0, 4'd1,  0, 0, 4'd1, 0));
        vecs.push_back(mk(1, 1, 4'd0, 0,   1, 3'd1, 4'd3,  0, 0, 4'd2, 0));
        vecs.push_back(mk(1, 1, 4'd0, 0,   1, 3'd2, 4'd2,  0, 0, 4'd3, 0));
        vecs.push_back(mk(1, 1, 4'd0, 0,   1, 3'd3, 4'd6,  0, 0, 4'd4, 0));
        vecs.push_back(mk(1, 1, 4'd0, 0,   1, 3'd4, 4'd7,  0, 0, 4'd5, 0));
        vecs.push_back(mk(1, 1, 4'd0, 0,   1, 3'd5, 4'd5,  0, 1, 4'd6, 0));
        vecs.push_back(mk(1, 1, 4'd0, 0,   1, 3'd6, 4'd4,  0, 1, 4'd7, 0));
        vecs.push_back(mk(1, 1, 4'd0, 0,   1, 3'd7, 4'd12, 1, 1, 4'd8, 0));
        // Writes while full: blocked, overflow sets and sticks.
        vecs.push_back(mk(1, 1, 4'd0, 0,   0, 3'd0, 4'd12, 1, 1, 4'd8, 1));
        vecs.push_back(mk(1, 1, 4'd0, 0,   0, 3'd0, 4'd12, 1, 1, 4'd8, 1));
        vecs.push_back(mk(1, 1, 4'd0, 0,   0, 3'd0, 4'd12, 1, 1, 4'd8, 1));
        vecs.push_back(mk(1, 0, 4'd0, 0,   0, 3'd0, 4'd12, 1, 1, 4'd8, 1));
        // Clear together with a new overflow: set wins.
        vecs.push_back(mk(1, 1, 4'd0, 1,   0, 3'd0, 4'd12, 1, 1, 4'd8, 1));
        vecs.push_back(mk(1, 0, 4'd0, 1,   0, 3'd0, 4'd12, 1, 1, 4'd8, 0));
        // One read: full drops three edges later.
        vecs.push_back(mk(1, 0, 4'd1, 0,   0, 3'd0, 4'd12, 1, 1, 4'd8, 0));
        vecs.push_back(mk(1, 0, 4'd1, 0,   0, 3'd0, 4'd12, 1, 1, 4'd8, 0));
        vecs.push_back(mk(1, 0, 4'd1, 0,   0, 3'd0, 4'd12, 0, 1, 4'd7, 0));
        // Two more reads: almost_full clears once level reaches 5.
        vecs.push_back(mk(1, 0, 4'd3, 0,   0, 3'd0, 4'd12, 0, 1, 4'd7, 0));
        vecs.push_back(mk(1, 0, 4'd3, 0,   0, 3'd0, 4'd12, 0, 1, 4'd7, 0));
        vecs.push_back(mk(1, 0, 4'd2, 0,   0, 3'd0, 4'd12, 0, 1, 4'd6, 0));
        vecs.push_back(mk(1, 0, 4'd2, 0,   0, 3'd0, 4'd12, 0, 1, 4'd6, 0));
        vecs.push_back(mk(1, 0, 4'd2, 0,   0, 3'd0, 4'd12, 0, 0, 4'd5, 0));
        // Write at level 5: almost_full rises with wlevel=6.
        vecs.push_back(mk(1, 1, 4'd2, 0,   1, 3'd0, 4'd13, 0, 1, 4'd6, 0));
        vecs.push_back(mk(1, 0, 4'd2, 0,   0, 3'd1, 4'd13, 0, 1, 4'd6, 0));
        // Refill to full past the pointer wrap bit, overflow, then read back to level 5.
        vecs.push_back(mk(1, 1, 4'd2, 0,   1, 3'd1, 4'd15, 0, 1, 4'd7, 0));
        vecs.push_back(mk(1, 1, 4'd2, 0,   1, 3'd2, 4'd14, 1, 1, 4'd8, 0));
        vecs.push_back(mk(1, 1, 4'd2, 0,   0, 3'd3, 4'd14, 1, 1, 4'd8, 1));
        vecs.push_back(mk(1, 0, 4'd5, 0,   0, 3'd3, 4'd14, 1, 1, 4'd8, 1));
        vecs.push_back(mk(1, 0, 4'd5, 0,   0, 3'd3, 4'd14, 1, 1, 4'd8, 1));
        vecs.push_back(mk(1, 0, 4'd5, 0,   0, 3'd3, 4'd14, 0, 0, 4'd5, 1));
        // Mid-operation reset with winc high: no write, everything cleared.
        vecs.push_back(mk(0, 1, 4'd5, 0,   0, 3'd3, 4'd0,  0, 0, 4'd0, 0));
        vecs.push_back(mk(1, 0, 4'd0, 0,   0, 3'd0, 4'd0,  0, 0, 4'd0, 0));
        vecs.push_back(mk(1, 1, 4'd0, 0,   1, 3'd0, 4'd1,  0, 0, 4'd1, 0));

        hard_reset();
        hard_reset();
        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], i);
        end

        // Wrap-around: 20 writes with the reader trailing; level settles at 3.
        hard_reset();
        for (int n = 0; n < 20; n++) begin
            vec_t v;
            int   used;
            used = (n >= 2) ? n - 2 : 0;
            v = mk(1, 1, g(n), 0, 1, 3'(n % 8), g((n + 1) % 16), 0, 0,
                   4'((n + 1 - used) % 16), 0);
            apply(v, 100 + n);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
